// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_ctrl_pkg
// Description : Shared defaults and FSM state type for the AES-128 decrypt
//               core controller.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

    // Pipeline latency of the attached decrypt core (data in -> result valid)
    localparam int unsigned c_DATA_LATENCY_DEFAULT = 11;
    // Cycles the round-key chain needs after core_key changes
    localparam int unsigned c_KEY_SETTLE_DEFAULT   = 10;
    // Result buffer depth; must cover a full pipeline plus one
    localparam int unsigned c_FIFO_DEPTH_DEFAULT   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aes_result_fifo
// Description : Synchronous result buffer with registered occupancy count.
//               Head word is presented combinationally from storage.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_result_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    // Storage write; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/aes_128_decrypt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_decrypt_ctrl
// Description : Flow controller for a fixed-latency AES-128 decrypt core.
//               Holds the key steady while blocks are in flight, waits for
//               the round-key chain to settle after a key change, and buffers
//               results so downstream backpressure never stalls the core.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_128_decrypt_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int DATA_LATENCY = c_DATA_LATENCY_DEFAULT,
    parameter int KEY_SETTLE   = c_KEY_SETTLE_DEFAULT,
    parameter int FIFO_DEPTH   = c_FIFO_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [127:0] core_data,
    output logic [127:0] core_key,
    input  logic [127:0] core_result,
    output logic         busy
);

    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;
    localparam int c_SW = (KEY_SETTLE > 1) ? $clog2(KEY_SETTLE) : 1;
    localparam logic [c_SW-1:0] c_SETTLE_LOAD = c_SW'(KEY_SETTLE - 1);
    localparam logic [c_CW:0]   c_DEPTH_LIMIT = (c_CW + 1)'(FIFO_DEPTH);

    ctrl_state_t             r_state;
    logic [127:0]            r_key;
    logic [c_SW-1:0]         r_settle_cnt;
    logic [DATA_LATENCY-1:0] r_valid_sr;
    logic [c_CW-1:0]         r_inflight;

    logic [DATA_LATENCY-1:0] w_sr_next;
    logic [c_CW-1:0]         w_fifo_count;
    logic [c_CW:0]           w_occupancy;
    logic                    w_key_match;
    logic                    w_credit_ok;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;

    // Admission: only in RUN, only for the loaded key, and only while every
    // block already committed (in the core or in the buffer) still has a slot.
    // A pop in the same cycle is deliberately not credited to keep this short.
    assign w_key_match = (in_key == r_key);
    assign w_occupancy = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign w_credit_ok = (w_occupancy < c_DEPTH_LIMIT);
    assign in_ready    = (r_state == ST_RUN) && w_key_match && w_credit_ok;

    assign w_accept    = in_valid && in_ready;
    assign w_push      = r_valid_sr[DATA_LATENCY-1];
    assign w_pop       = out_valid && out_ready;

    assign core_data   = in_data;
    assign core_key    = r_key;
    assign busy        = (r_state != ST_IDLE) || (r_inflight != '0) || (w_fifo_count != '0);

    generate
        if (DATA_LATENCY > 1) begin : g_sr_multi
            assign w_sr_next = {r_valid_sr[DATA_LATENCY-2:0], w_accept};
        end else begin : g_sr_single
            assign w_sr_next = w_accept;
        end
    endgenerate

    // Control FSM: key is only reloaded when nothing is inside the core
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_key        <= '0;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_key        <= in_key;
                        r_settle_cnt <= c_SETTLE_LOAD;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (in_valid && !w_key_match) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_inflight == '0) begin
                        r_key        <= in_key;
                        r_settle_cnt <= c_SETTLE_LOAD;
                        r_state      <= ST_SETTLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Valid tracker mirrors the core pipeline; inflight is its popcount
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_sr <= '0;
            r_inflight <= '0;
        end else begin
            r_valid_sr <= w_sr_next;
            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    aes_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (128)
    ) u_result_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (core_result),
        .i_pop       (w_pop),
        .o_head      (out_data),
        .o_count     (w_fifo_count)
    );

    assign out_valid = (w_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_aes_128_decrypt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_128_decrypt_ctrl
// Description : Self-checking bench for aes_128_decrypt_ctrl with a
//               fixed-latency stand-in decrypt core and an ordered
//               result/timing scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_128_decrypt_ctrl;

    localparam int c_LAT    = 11;
    localparam int c_SETTLE = 10;
    localparam int c_DEPTH  = 16;

    localparam logic [127:0] c_KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_KEYB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_PT   = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic [127:0] core_data;
    logic [127:0] core_key;
    logic [127:0] core_result;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard: expected plaintexts and earliest cycle each may appear
    logic [127:0] exp_q[$];
    int           rdy_q[$];
    int           pop_cnt   = 0;
    int           first_pop = -1;
    int           last_pop  = -1;

    aes_128_decrypt_ctrl #(
        .DATA_LATENCY (c_LAT),
        .KEY_SETTLE   (c_SETTLE),
        .FIFO_DEPTH   (c_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_key      (in_key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .core_data   (core_data),
        .core_key    (core_key),
        .core_result (core_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in decrypt function: the FIPS-197 vector maps to its plaintext,
    // anything else to a key-dependent scramble so wrong keys are visible.
    function automatic logic [127:0] core_f(input logic [127:0] d, input logic [127:0] k);
        if (d == c_CT && k == c_KEY0) return c_PT;
        return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    logic [127:0] pipe [c_LAT];

    always @(posedge clk) begin
        pipe[0] <= core_f(core_data, core_key);
        for (int i = 1; i < c_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_result = pipe[c_LAT-1];

    task automatic chk(input string name, input bit ok, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [127:0] blk(input int i);
        return {32'hC0DE0000 + 32'(i), 32'h12345678 ^ 32'(i), 32'h9abcdef0 + 32'(3 * i), 32'(i)};
    endfunction

    // Compare process: every cycle, outputs against the ordered timing model
    always @(negedge clk) begin
        bit exp_ov;
        if (reset) begin
            exp_q.delete();
            rdy_q.delete();
        end else begin
            exp_ov = 1'b0;
            if (exp_q.size() > 0) exp_ov = (cyc >= rdy_q[0]);
            chk("out_valid", out_valid == exp_ov, 128'(out_valid), 128'(exp_ov));
            if (exp_ov && out_valid) chk("out_data", out_data == exp_q[0], out_data, exp_q[0]);
            if (in_ready) chk("credit", exp_q.size() < c_DEPTH, 128'(exp_q.size()), 128'(c_DEPTH - 1));
            if (in_valid && in_ready) begin
                chk("core_key", core_key == in_key, core_key, in_key);
                chk("core_data", core_data == in_data, core_data, in_data);
                exp_q.push_back(core_f(in_data, in_key));
                rdy_q.push_back(cyc + c_LAT + 1);
            end
            if (out_valid && out_ready && exp_ov) begin
                void'(exp_q.pop_front());
                void'(rdy_q.pop_front());
                if (pop_cnt == 0) first_pop = cyc;
                last_pop = cyc;
                pop_cnt++;
            end
        end
    end

    // Offer one block; leaves in_valid held if not accepted within budget
    task automatic send(input logic [127:0] d, input logic [127:0] k, input int budget,
                        output bit ok, output int acc);
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        ok       = 1'b0;
        acc      = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok  = 1'b1;
                acc = cyc;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        chk(name, done, 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int acc, a0, alast, c0, t, n_acc, idx;
        bit stale;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready == 1'b0, 128'(in_ready), 128'(0));
        chk("rst_out_valid", out_valid == 1'b0, 128'(out_valid), 128'(0));
        chk("rst_busy", busy == 1'b0, 128'(busy), 128'(0));
        chk("rst_core_key", core_key == '0, core_key, 128'(0));
        @(posedge clk);
        #1;

        // FIPS-197 vector from reset: settle then fixed latency
        c0 = cyc;
        send(c_CT, c_KEY0, 40, ok, acc);
        chk("vec_accept", ok, 128'(ok), 128'(1));
        chk("vec_ready_delay", (acc - c0) == 11, 128'(acc - c0), 128'(11));
        t = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) begin
                t = cyc;
                break;
            end
        end
        chk("vec_latency", (t - acc) == 12, 128'(t - acc), 128'(12));
        chk("vec_plaintext", out_data == c_PT, out_data, c_PT);
        @(posedge clk);
        #1;
        wait_drain("vec_drain", 40);

        // 20 back-to-back same-key blocks
        pop_cnt = 0;
        n_acc = 0;
        a0 = -1;
        alast = -1;
        for (int i = 0; i < 20; i++) begin
            send(blk(i), c_KEY0, 30, ok, acc);
            if (ok) begin
                n_acc++;
                if (i == 0) a0 = acc;
                alast = acc;
            end
        end
        chk("b2b_accepts", n_acc == 20, 128'(n_acc), 128'(20));
        chk("b2b_span", (alast - a0) == 19, 128'(alast - a0), 128'(19));
        wait_drain("b2b_drain", 80);
        chk("b2b_pops", pop_cnt == 20, 128'(pop_cnt), 128'(20));
        chk("b2b_out_span", (last_pop - first_pop) == 19, 128'(last_pop - first_pop), 128'(19));

        // Backpressure: exactly FIFO_DEPTH blocks admitted
        out_ready = 1'b0;
        pop_cnt = 0;
        n_acc = 0;
        idx = 30;
        for (int i = 0; i < 30; i++) begin
            send(blk(100 + i), c_KEY0, 40, ok, acc);
            if (!ok) begin
                idx = i;
                break;
            end
            n_acc++;
        end
        chk("bp_accepts", n_acc == 16, 128'(n_acc), 128'(16));
        chk("bp_in_ready", in_ready == 1'b0, 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(blk(100 + idx), c_KEY0, 40, ok, acc);
        chk("bp_resume", ok, 128'(ok), 128'(1));
        for (int i = idx + 1; i < 30; i++) send(blk(100 + i), c_KEY0, 40, ok, acc);
        wait_drain("bp_drain", 120);
        chk("bp_pops", pop_cnt == 30, 128'(pop_cnt), 128'(30));

        // Key change mid-stream: drain, settle, resume
        for (int i = 0; i < 3; i++) send(blk(200 + i), c_KEY0, 30, ok, alast);
        send(blk(300), c_KEYB, 60, ok, acc);
        chk("kc_accept", ok, 128'(ok), 128'(1));
        chk("kc_gap", (acc - alast) == 23, 128'(acc - alast), 128'(23));
        for (int i = 1; i < 4; i++) send(blk(300 + i), c_KEYB, 30, ok, acc);
        wait_drain("kc_drain", 60);

        // Reset with 5 blocks in flight
        for (int i = 0; i < 5; i++) send(blk(400 + i), c_KEYB, 30, ok, acc);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid == 1'b0, 128'(out_valid), 128'(0));
        chk("mid_rst_busy", busy == 1'b0, 128'(busy), 128'(0));
        chk("mid_rst_in_ready", in_ready == 1'b0, 128'(in_ready), 128'(0));
        chk("mid_rst_core_key", core_key == '0, core_key, 128'(0));
        stale = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("mid_rst_no_stale", stale == 1'b0, 128'(stale), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_128_decrypt_ctrl.md
AES_128_DECRYPT_CTRL -- requirements
Module: aes_128_decrypt_ctrl

Interface
REQ-001 SHALL have parameter DATA_LATENCY, default 11: cycles from core_data presented to core_result valid.
REQ-002 SHALL have parameter KEY_SETTLE, default 10: cycles after a core_key change before the round-key chain is valid.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16 (power of 2, >= DATA_LATENCY+1): result buffer depth.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  ciphertext block and key offered.
REQ-007 in_ready  out  1  block accepted this cycle when in_valid&in_ready.
REQ-008 in_data  in  128  ciphertext.
REQ-009 in_key  in  128  cipher key for this block.
REQ-010 out_valid  out  1  plaintext available.
REQ-011 out_ready  in  1  consumer accepts plaintext.
REQ-012 out_data  out  128  plaintext.
REQ-013 core_data  out  128  to decrypt core data input.
REQ-014 core_key  out  128  to decrypt core key input.
REQ-015 core_result  in  128  from decrypt core output.
REQ-016 busy  out  1  state != IDLE, or blocks in flight, or FIFO non-empty.

Function
REQ-017 SHALL implement FSM IDLE, SETTLE, RUN, DRAIN.
REQ-018 IDLE: in_ready=0; in_valid -> key_reg<=in_key, counter<=KEY_SETTLE-1, go SETTLE.
REQ-019 SETTLE: in_ready=0; decrement counter; at 0 -> RUN.
REQ-020 RUN: in_ready = (in_key==key_reg) && (inflight+fifo_count < FIFO_DEPTH); same-cycle FIFO pop not credited.
REQ-021 RUN: in_valid with in_key!=key_reg -> DRAIN, in_ready=0.
REQ-022 DRAIN: in_ready=0; when inflight==0 -> key_reg<=in_key, counter<=KEY_SETTLE-1, go SETTLE; FIFO contents retained and drained normally.
REQ-023 Upstream SHALL hold in_valid, in_data, in_key stable until accepted; controller need not handle withdrawal.
REQ-024 core_key SHALL be key_reg (registered); key_reg changes only in IDLE/DRAIN transitions, never while inflight>0.
REQ-025 core_data SHALL equal in_data combinationally.
REQ-026 Acceptance in cycle t SHALL set bit 0 of a DATA_LATENCY-bit valid shift register; bit DATA_LATENCY-1 set in cycle t+DATA_LATENCY-1 SHALL push core_result into FIFO at end of cycle t+DATA_LATENCY; first out_valid in cycle t+DATA_LATENCY+1 (12 cycles default).
REQ-027 inflight SHALL equal popcount of shift register, maintained as counter (+1 accept, -1 push, both -> unchanged).
REQ-028 Sustained throughput 1 block/cycle with same key and out_ready=1.
REQ-029 FIFO simultaneous push and pop SHALL keep count; pop only when out_valid&out_ready; push never blocked (credit guarantees space); pointers wrap modulo FIFO_DEPTH.
REQ-030 out_data SHALL hold FIFO head, stable while out_valid&!out_ready; results in acceptance order.

Reset
REQ-031 reset SHALL force state IDLE, key_reg=0, counter=0, shift register=0, inflight=0, FIFO empty.
REQ-032 Outputs during/after reset: in_ready=0, out_valid=0, busy=0, core_key=0; out_data don't-care.
REQ-033 reset mid-operation SHALL discard in-flight and buffered blocks; no result emerges afterward.

Structure
REQ-034 Package aes_ctrl_pkg SHALL hold DATA_LATENCY/KEY_SETTLE defaults and the FSM state type.
REQ-035 Result buffer SHALL be sub-module aes_result_fifo (synchronous, registered count).

Verification
REQ-036 key 000102030405060708090a0b0c0d0e0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a from reset -> in_ready after 11 cycles (IDLE+SETTLE), out_data 00112233445566778899aabbccddeeff 12 cycles after accept.
REQ-037 20 same-key blocks, out_ready=1 -> accepted back-to-back, 20 outputs consecutive, in order.
REQ-038 out_ready=0, 30 same-key blocks -> exactly 16 accepted, in_ready low; raise out_ready -> all 16 out in order, acceptance resumes.
REQ-039 key change mid-stream -> DRAIN until inflight=0, SETTLE 10 cycles, new-key results correct, no old-key block lost.
REQ-040 reset asserted with 5 blocks in flight -> out_valid=0, busy=0 next cycle, no stale output after.
